// File: rtl/compression_package.sv
// Shared definitions for the 1-bit compressed-sensing compressor and its receive-side decompressor:
// measurement matrix codes, the Phi_var matrix lookup and the signed weight decode.
package compression_package;

    localparam int PHI_ROWS = 96;
    localparam int PHI_COLS = 64;

    typedef enum logic [1:0] {
        PHI_ZERO = 2'b00,
        PHI_POS  = 2'b01,
        PHI_NEG2 = 2'b10,
        PHI_NEG  = 2'b11
    } phi_code_t;

    // Matrix entry at (row, col); a fixed arithmetic mix, so it folds to logic wherever it is used.
    function automatic phi_code_t Phi_var(input int row, input int col);
        int mix;
        mix = row + col * ((row >> 2) + 1) + (col >> 1);
        return phi_code_t'(mix[1:0]);
    endfunction

    // Signed weight of one matrix entry; a set sign bit means a negative measurement.
    function automatic logic signed [2:0] phi_weight(input phi_code_t code, input logic sign);
        logic signed [2:0] w;
        case (code)
            PHI_ZERO: w = 3'sd0;
            PHI_POS:  w = 3'sd1;
            PHI_NEG2: w = -3'sd2;
            default:  w = -3'sd1;
        endcase
        return sign ? -w : w;
    endfunction

endpackage

// File: rtl/block_decompression_column_sum.sv
// Combinational per-word partial back-projection for one column:
// sum over the DEPTH rows of this word of the sign-adjusted Phi weight.
module phi_column_sum
    import compression_package::*;
#(
    parameter int DEPTH       = 12,
    parameter int WORDS       = 8,
    parameter int INDEX_WIDTH = 6,
    parameter int ACC_WIDTH   = 10,
    localparam int WC_WIDTH   = $clog2(WORDS)
) (
    input  logic [WC_WIDTH-1:0]    word_count_i,
    input  logic [INDEX_WIDTH-1:0] col_i,
    input  logic [DEPTH-1:0]       sign_word_i,
    output logic [ACC_WIDTH-1:0]   partial_o
);

    logic signed [2:0] weight [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        assign weight[gi] = phi_weight(Phi_var(gi + DEPTH * int'(word_count_i), int'(col_i)),
                                       sign_word_i[gi]);
    end

    always_comb begin
        partial_o = '0;
        for (int l = 0; l < DEPTH; l++) begin
            partial_o = partial_o + {{(ACC_WIDTH-3){weight[l][2]}}, weight[l]};
        end
    end

endmodule

// File: rtl/block_decompression.sv
// Receive-side back-projection (Phi^T * y) of WORDS sign words per block for four selected columns.
// Blocks may be aborted by sof_in mid-block; the aborting word starts the next block.
module block_decompression
    import compression_package::*;
#(
    parameter int DEPTH       = 12,
    parameter int WORDS       = 8,
    parameter int INDEX_WIDTH = 6,
    parameter int ACC_WIDTH   = 10,
    localparam int WC_WIDTH   = $clog2(WORDS),
    localparam int LANES      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic                         sof_in,
    input  logic [DEPTH-1:0]             data_in,
    input  logic [LANES*INDEX_WIDTH-1:0] index_in,
    output logic [LANES*ACC_WIDTH-1:0]   est_out,
    output logic                         valid_out,
    output logic                         busy,
    output logic                         sync_err
);

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    state_t                 state;
    logic [WC_WIDTH-1:0]    word_count_q, word_count_d, lookup_wc;
    logic [INDEX_WIDTH-1:0] idx_q [LANES];
    logic [INDEX_WIDTH-1:0] idx_d [LANES];
    logic [INDEX_WIDTH-1:0] lookup_idx [LANES];
    logic [ACC_WIDTH-1:0]   acc_q [LANES];
    logic [ACC_WIDTH-1:0]   acc_d [LANES];
    logic [ACC_WIDTH-1:0]   est_q [LANES];
    logic [ACC_WIDTH-1:0]   est_d [LANES];
    logic [ACC_WIDTH-1:0]   partial [LANES];
    logic                   valid_out_q, valid_out_d;
    logic                   sync_err_q, sync_err_d;
    logic                   start;

    assign state = (word_count_q == '0) ? ST_IDLE : ST_ACCUM;
    // A word opens a block when idle, or when sof_in forces a resync mid-block.
    assign start     = valid_in && ((state == ST_IDLE) || sof_in);
    assign lookup_wc = start ? '0 : word_count_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lookup_idx[gi] = start ? index_in[gi*INDEX_WIDTH +: INDEX_WIDTH] : idx_q[gi];
        assign est_out[gi*ACC_WIDTH +: ACC_WIDTH] = est_q[gi];

        phi_column_sum #(
            .DEPTH       (DEPTH),
            .WORDS       (WORDS),
            .INDEX_WIDTH (INDEX_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_column_sum (
            .word_count_i (lookup_wc),
            .col_i        (lookup_idx[gi]),
            .sign_word_i  (data_in),
            .partial_o    (partial[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
            valid_out_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                idx_q[j] <= '0;
                acc_q[j] <= '0;
                est_q[j] <= '0;
            end
        end else begin
            word_count_q <= word_count_d;
            valid_out_q  <= valid_out_d;
            sync_err_q   <= sync_err_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            est_q        <= est_d;
        end
    end

    always_comb begin
        word_count_d = word_count_q;
        valid_out_d  = 1'b0;
        sync_err_d   = 1'b0;
        idx_d        = idx_q;
        acc_d        = acc_q;
        est_d        = est_q;
        if (valid_in) begin
            if (start) begin
                word_count_d = WC_WIDTH'(1);
                sync_err_d   = (state == ST_ACCUM);
                idx_d        = lookup_idx;
                acc_d        = partial;
            end else begin
                for (int j = 0; j < LANES; j++) begin
                    acc_d[j] = acc_q[j] + partial[j];
                end
                if (word_count_q == WC_WIDTH'(WORDS-1)) begin
                    word_count_d = '0;
                    valid_out_d  = 1'b1;
                    est_d        = acc_d;
                end else begin
                    word_count_d = word_count_q + WC_WIDTH'(1);
                end
            end
        end
    end

    assign valid_out = valid_out_q;
    assign sync_err  = sync_err_q;
    assign busy      = (state == ST_ACCUM);

endmodule

// File: tb/tb_block_decompression.sv
// Directed self-checking bench for block_decompression: expected estimates come from a
// behavioural sum over the Phi matrix plus hand-derived constants for column 0.
module tb_block_decompression;
    import compression_package::*;

    localparam int DEPTH = 12;
    localparam int WORDS = 8;
    localparam int IW    = 6;
    localparam int AW    = 10;

    typedef logic [DEPTH-1:0] blk_t [WORDS];

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          sof_in;
    logic [11:0]   data_in;
    logic [23:0]   index_in;
    logic [39:0]   est_out;
    logic          valid_out;
    logic          busy;
    logic          sync_err;

    int n_pass    = 0;
    int n_checks  = 0;
    int valid_cnt = 0;
    int serr_cnt  = 0;
    int last_res [4];
    int saved_res [4];

    always #5 clk = ~clk;

    block_decompression dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .data_in   (data_in),
        .index_in  (index_in),
        .est_out   (est_out),
        .valid_out (valid_out),
        .busy      (busy),
        .sync_err  (sync_err)
    );

    always @(negedge clk) begin
        if (valid_out === 1'b1) valid_cnt++;
        if (sync_err === 1'b1) serr_cnt++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic signed [31:0] lane(input int j);
        logic signed [AW-1:0] v;
        v = est_out[j*AW +: AW];
        return v;
    endfunction

    function automatic int tb_weight(input int row, input int col, input logic s);
        int w;
        case (Phi_var(row, col))
            PHI_ZERO: w = 0;
            PHI_POS:  w = 1;
            PHI_NEG2: w = -2;
            default:  w = -1;
        endcase
        return s ? -w : w;
    endfunction

    function automatic int model(input blk_t w, input int col);
        int s = 0;
        for (int r = 0; r < WORDS*DEPTH; r++) s += tb_weight(r, col, w[r/DEPTH][r%DEPTH]);
        return s;
    endfunction

    function automatic logic [23:0] pack_idx(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic send(input logic [11:0] d, input logic [23:0] idx, input logic sof);
        valid_in = 1'b1;
        sof_in   = sof;
        data_in  = d;
        index_in = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic pause(input int n);
        valid_in = 1'b0;
        sof_in   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string tag, input blk_t w, input logic [23:0] idx, input int gap,
                             input bit junk, input bit sof_first, input bit expect_abort);
        for (int k = 0; k < WORDS; k++) begin
            send(w[k], (junk && k > 0) ? 24'($urandom) : idx, (k == 0) ? sof_first : 1'b0);
            if (k == 0) chk({tag, " sync_err"}, 32'(sync_err), 32'(expect_abort));
            if (k < WORDS-1) begin
                chk({tag, " busy mid"}, 32'(busy), 1);
                chk({tag, " valid_out early"}, 32'(valid_out), 0);
                if (gap > 0) begin
                    pause(gap);
                    chk({tag, " busy gap"}, 32'(busy), 1);
                end
            end
        end
        chk({tag, " valid_out"}, 32'(valid_out), 1);
        chk({tag, " busy end"}, 32'(busy), 0);
        for (int j = 0; j < 4; j++) begin
            last_res[j] = lane(j);
            chk($sformatf("%s lane%0d", tag, j), lane(j), model(w, int'(idx[j*IW +: IW])));
        end
        $display("block %s: est = %0d %0d %0d %0d", tag, last_res[0], last_res[1], last_res[2], last_res[3]);
    endtask

    blk_t wz, wf, wd, we, wb1, wb2;
    logic [23:0] idx0, idxs;
    int v0, s0;

    initial begin
        wz   = '{default: 12'h000};
        wf   = '{default: 12'hFFF};
        wd   = '{12'hA5C, 12'h3F0, 12'h0F3, 12'hC96, 12'h5A5, 12'h001, 12'h800, 12'h7E1};
        we   = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h0F0, 12'hF0F, 12'h555};
        wb1  = '{default: 12'hAAA};
        wb2  = '{12'h111, 12'h222, 12'h444, 12'h888, 12'hEEE, 12'hDDD, 12'hBBB, 12'h777};
        idx0 = pack_idx(0, 0, 0, 0);
        idxs = pack_idx(5, 17, 40, 63);

        rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; data_in = '0; index_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset est", 32'(est_out), 0);
        chk("reset valid_out", 32'(valid_out), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset sync_err", 32'(sync_err), 0);
        rst = 1'b0;

        // Column 0 codes cycle 0,+1,-2,-1 down the rows: -2 per four rows, -48 per block.
        run_block("zeros col0", wz, idx0, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) chk("zeros const", lane(j), -48);
        pause(1);
        chk("valid_out one cycle", 32'(valid_out), 0);
        chk("est holds", lane(2), -48);

        run_block("ones col0", wf, idx0, 0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) chk("ones const", lane(j), 48);
        pause(1);

        run_block("mixed idx", wd, idxs, 0, 1'b0, 1'b1, 1'b0);
        saved_res = last_res;
        pause(2);

        run_block("gapped junk", wd, idxs, 3, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) chk("gapped matches gapless", lane(j), saved_res[j]);
        pause(1);

        v0 = valid_cnt;
        run_block("b2b first", wb1, idxs, 0, 1'b0, 1'b0, 1'b0);
        run_block("b2b second", wb2, pack_idx(1, 2, 3, 62), 0, 1'b0, 1'b0, 1'b0);
        pause(1);
        chk("b2b pulse count", valid_cnt - v0, 2);

        v0 = valid_cnt;
        s0 = serr_cnt;
        for (int k = 0; k < 4; k++) send(wd[k], idxs, 1'b0);
        run_block("abort restart", we, pack_idx(9, 33, 0, 50), 0, 1'b0, 1'b1, 1'b1);
        pause(1);
        chk("abort sync_err count", serr_cnt - s0, 1);
        chk("abort valid count", valid_cnt - v0, 1);

        v0 = valid_cnt;
        for (int k = 0; k < 4; k++) send(wb2[k], idxs, 1'b0);
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst est", 32'(est_out), 0);
        chk("mid rst valid_out", 32'(valid_out), 0);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst sync_err", 32'(sync_err), 0);
        rst = 1'b0;
        run_block("after rst", wd, pack_idx(63, 62, 7, 8), 0, 1'b0, 1'b0, 1'b0);
        pause(1);
        chk("after rst valid count", valid_cnt - v0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
